vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, pixel/host data width.
REQ-002 Parameter ADDR_W, default 17, VRAM word address width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 display_on  in  1  visible-area flag from the VGA sync generator.
REQ-006 screen_x  in  10  half-resolution column, 0..399.
REQ-007 screen_y  in  9  half-resolution row, 0..299.
REQ-008 pix_data  out  DATA_W  pixel read for display.
REQ-009 pix_valid  out  1  pix_data holds a fresh display read.
REQ-010 host_valid  in  1  host request present.
REQ-011 host_ready  out  1  host request accepted this cycle.
REQ-012 host_we  in  1  1 = write, 0 = read.
REQ-013 host_addr  in  ADDR_W  host word address.
REQ-014 host_wdata  in  DATA_W  host write data.
REQ-015 host_rdata  out  DATA_W  host read data.
REQ-016 host_rvalid  out  1  host_rdata valid, one pulse per accepted read.
REQ-017 mem_en, mem_we  out  1 each  VRAM port enable / write enable.
REQ-018 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W (1-cycle read latency).

Function
REQ-019 Block SHALL share one single-port VRAM between display fetch (high priority) and host (low priority), one access per cycle.
REQ-020 Display slot: cycle where display_on=1 and screen_x differs from previous cycle's registered screen_x, or display_on rose this cycle.
REQ-021 Display slot SHALL issue read at mem_addr = screen_y*400 + screen_x (shift-add, no multiplier), result fits 17 bits (max 119999).
REQ-022 Display read data SHALL appear on pix_data with pix_valid=1 exactly 2 cycles after the slot (1 memory + 1 output register); pix_data holds between reads.
REQ-023 host_ready SHALL be combinational: host_valid=1 and no display slot this cycle.
REQ-024 Accepted host write SHALL drive mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata that cycle; no response.
REQ-025 Accepted host read SHALL produce host_rvalid=1 with host_rdata 2 cycles after acceptance.
REQ-026 Read-owner tag SHALL be a 2-state pipeline (DISP, HOST) plus NONE, steering mem_rdata to the correct output; never both valids in same cycle.
REQ-027 During active display, slots alternate, so a waiting host SHALL be accepted within 2 cycles; during blanking, every cycle.
REQ-028 host_valid held while not ready SHALL keep request fields stable; block needs no queuing.
REQ-029 mem_en=0 on cycles with no access; mem_we=0 for all reads.

Reset
REQ-030 Asynchronous assertion SHALL force pix_data=0, pix_valid=0, host_rdata=0, host_rvalid=0, mem_en=0, mem_we=0, owner pipeline NONE, prev screen_x=0.
REQ-031 Reset mid-transaction SHALL drop in-flight reads; no rvalid/pix_valid issued afterwards for them.

Configuration
REQ-032 Macro VRAM_ARB_BLANK_ONLY_EN defined: host_ready SHALL be 0 whenever display_on=1 (host served only in blanking); undefined: REQ-023 applies.

Structure
REQ-033 Shared package vga_pkg SHALL hold H_PIX=400, V_PIX=300, ADDR_W default, and the read-owner enum.
REQ-034 Sub-module vga_addr_gen SHALL compute screen_y*400+screen_x combinationally.

Verification
REQ-035 Display row y=2, x steps 0->1: reads at addr 800, 801; pix_data equals preloaded VRAM values, 2 cycles later.
REQ-036 Host write addr 5 data 0xA5 during blanking: accepted same cycle; subsequent host read addr 5 -> host_rvalid with 0xA5 after 2 cycles.
REQ-037 Host read held through active display: host_ready within 2 cycles, never coincident with a display slot; no pix_valid lost.
REQ-038 VRAM_ARB_BLANK_ONLY_EN defined, host_valid=1 throughout a line: host_ready=0 while display_on=1, 1 on first blanking cycle.
REQ-039 rst pulsed with host read and display read in flight: all outputs 0 immediately; no rvalid/pix_valid pulses following.
REQ-040 Last pixel x=399, y=299: mem_addr=119999, no overflow.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, default VRAM address width and read-owner tag
package vga_pkg;
  localparam int H_PIX = 400;
  localparam int V_PIX = 300;
  localparam int ADDR_W_DEF = 17;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_HOST} owner_t;
endpackage

// File: rtl/vga_addr_gen.sv
// vga_addr_gen: linear VRAM address y*400+x built from shifts (400 = 256+128+16)
module vga_addr_gen #(
  parameter int ADDR_W = 17
) (
  input  logic [9:0]        screen_x,
  input  logic [8:0]        screen_y,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] yw;
  assign yw = ADDR_W'(screen_y);
  assign addr = (yw << 8) + (yw << 7) + (yw << 4) + ADDR_W'(screen_x);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM shared by display fetch (priority) and host.
// VRAM_ARB_BLANK_ONLY_EN: host served only while display_on=0.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display_on,
  input  logic [9:0]        screen_x,
  input  logic [8:0]        screen_y,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [9:0]        prev_x;
  logic              prev_on;
  logic              slot;
  logic [ADDR_W-1:0] disp_addr;
  owner_t            own, own_n;
  vga_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .screen_x(screen_x),
    .screen_y(screen_y),
    .addr    (disp_addr)
  );
  // rst gates the combinational port so nothing reaches VRAM while in reset
  always_comb begin
    slot = !rst && display_on && (screen_x != prev_x || !prev_on);
`ifdef VRAM_ARB_BLANK_ONLY_EN
    host_ready = !rst && host_valid && !display_on;
`else
    host_ready = !rst && host_valid && !slot;
`endif
    mem_en = slot || host_ready;
    mem_we = !slot && host_ready && host_we;
    mem_addr = slot ? disp_addr : host_addr;
    mem_wdata = host_wdata;
    own_n = slot ? OWN_DISP : (host_ready && !host_we) ? OWN_HOST : OWN_NONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_x <= '0;
      prev_on <= 1'b0;
      own <= OWN_NONE;
      pix_data <= '0;
      pix_valid <= 1'b0;
      host_rdata <= '0;
      host_rvalid <= 1'b0;
    end else begin
      prev_x <= screen_x;
      prev_on <= display_on;
      own <= own_n;
      pix_valid <= own == OWN_DISP;
      host_rvalid <= own == OWN_HOST;
      if (own == OWN_DISP) pix_data <= mem_rdata;
      if (own == OWN_HOST) host_rdata <= mem_rdata;
    end
  end
endmodule
